// File: rtl/otter_pipe_pkg.sv
// Shared types and constants for the OTTER pipeline hazard logic:
// controller states, forwarding selects, PC source codes and the x0 index.
package otter_pipe_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    FREEZE = 2'd1,
    ERROR  = 2'd2
  } hz_state_e;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_MEM = 2'd1;
  localparam logic [1:0] FWD_WB  = 2'd2;

  localparam logic [1:0] PC_SRC_NEXT   = 2'd0;
  localparam logic [1:0] PC_SRC_JALR   = 2'd1;
  localparam logic [1:0] PC_SRC_BRANCH = 2'd2;
  localparam logic [1:0] PC_SRC_JAL    = 2'd3;

  localparam logic [4:0] X0 = 5'd0;

  // A producer only matches a consumer when it really writes a non-x0 register.
  function automatic logic rd_hit(input logic we, input logic [4:0] rd, input logic [4:0] rs);
    return we && (rd != X0) && (rd == rs);
  endfunction

  function automatic logic is_redirect(input logic [1:0] pc_src);
    case (pc_src)
      PC_SRC_JALR, PC_SRC_BRANCH, PC_SRC_JAL: return 1'b1;
      PC_SRC_NEXT:                            return 1'b0;
      default:                                return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/otter_forward_unit.sv
// Combinational ALU operand forwarding select for one source register.
// The younger MEM-stage result wins over the WB-stage result.
module otter_forward_unit
  import otter_pipe_pkg::*;
(
  input  logic [4:0] ex_rs,
  input  logic [4:0] mem_rd,
  input  logic       mem_regwrite,
  input  logic [4:0] wb_rd,
  input  logic       wb_regwrite,
  output logic [1:0] fwd_sel
);

  logic mem_match;
  logic wb_match;

  assign mem_match = rd_hit(mem_regwrite, mem_rd, ex_rs);
  assign wb_match  = rd_hit(wb_regwrite, wb_rd, ex_rs);

  always_comb begin
    fwd_sel = FWD_RF;
    if (mem_match) begin
      fwd_sel = FWD_MEM;
    end else if (wb_match) begin
      fwd_sel = FWD_WB;
    end
  end

endmodule

// File: rtl/otter_hazard_controller.sv
// Stall/flush/forwarding controller for the 5-stage OTTER pipeline, with
// memory-busy freeze, saturating performance counters and a wait watchdog.
module otter_hazard_controller
  import otter_pipe_pkg::*;
#(
  parameter int CNT_W    = 32,
  parameter int WAIT_MAX = 15
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [4:0]       DEC_RS1,
  input  logic [4:0]       DEC_RS2,
  input  logic             DEC_USES_RS1,
  input  logic             DEC_USES_RS2,
  input  logic [4:0]       EX_RS1,
  input  logic [4:0]       EX_RS2,
  input  logic [4:0]       EX_RD,
  input  logic             EX_REGWRITE,
  input  logic             EX_MEMREAD2,
  input  logic [1:0]       EX_PCSOURCE,
  input  logic [4:0]       MEM_RD,
  input  logic             MEM_REGWRITE,
  input  logic [4:0]       WB_RD,
  input  logic             WB_REGWRITE,
  input  logic             MEM_BUSY,
  output logic             PC_WRITE,
  output logic             IF_ID_WRITE,
  output logic             ID_EX_WRITE,
  output logic             EX_MEM_WRITE,
  output logic             IF_ID_FLUSH,
  output logic             ID_EX_FLUSH,
  output logic [1:0]       FWD_A_SEL,
  output logic [1:0]       FWD_B_SEL,
  output logic [CNT_W-1:0] STALL_CNT,
  output logic [CNT_W-1:0] FLUSH_CNT,
  output logic [CNT_W-1:0] FREEZE_CNT,
  output logic             ERR
);

  localparam int WAIT_W = $clog2(WAIT_MAX + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(WAIT_MAX);
  localparam logic [WAIT_W-1:0] WAIT_ONE   = WAIT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_FULL   = {CNT_W{1'b1}};

  hz_state_e         state_reg, state_next;
  logic [WAIT_W-1:0] wait_reg, wait_next;
  logic              err_reg, err_next;
  logic [CNT_W-1:0]  stall_cnt_reg, stall_cnt_next;
  logic [CNT_W-1:0]  flush_cnt_reg, flush_cnt_next;
  logic [CNT_W-1:0]  freeze_cnt_reg, freeze_cnt_next;

  logic load_use;
  logic redirect;
  logic stall_evt, flush_evt, freeze_evt;
  logic pc_w, if_id_w, id_ex_w, ex_mem_w, if_id_f, id_ex_f;

  logic [4:0] op_rs  [2];
  logic [1:0] op_fwd [2];

  assign op_rs[0] = EX_RS1;
  assign op_rs[1] = EX_RS2;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fwd
      otter_forward_unit u_fwd (
        .ex_rs        (op_rs[gi]),
        .mem_rd       (MEM_RD),
        .mem_regwrite (MEM_REGWRITE),
        .wb_rd        (WB_RD),
        .wb_regwrite  (WB_REGWRITE),
        .fwd_sel      (op_fwd[gi])
      );
    end
  endgenerate

  assign load_use = EX_MEMREAD2 &&
                    ((DEC_USES_RS1 && rd_hit(EX_REGWRITE, EX_RD, DEC_RS1)) ||
                     (DEC_USES_RS2 && rd_hit(EX_REGWRITE, EX_RD, DEC_RS2)));
  assign redirect = is_redirect(EX_PCSOURCE);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic ev);
    return (ev && (v != CNT_FULL)) ? (v + CNT_ONE) : v;
  endfunction

  always_comb begin
    state_next = state_reg;
    wait_next  = wait_reg;
    err_next   = err_reg;
    stall_evt  = 1'b0;
    flush_evt  = 1'b0;
    freeze_evt = 1'b0;
    pc_w       = 1'b0;
    if_id_w    = 1'b0;
    id_ex_w    = 1'b0;
    ex_mem_w   = 1'b0;
    if_id_f    = 1'b0;
    id_ex_f    = 1'b0;

    case (state_reg)
      RUN, FREEZE: begin
        if (MEM_BUSY) begin
          // Everything holds; a pending redirect/load-use is re-judged once the bus frees.
          freeze_evt = 1'b1;
          wait_next  = (state_reg == RUN) ? WAIT_ONE : (wait_reg + WAIT_ONE);
          if (wait_next >= WAIT_LIMIT) begin
            state_next = ERROR;
            err_next   = 1'b1;
          end else begin
            state_next = FREEZE;
          end
        end else begin
          state_next = RUN;
          wait_next  = '0;
          pc_w       = 1'b1;
          if_id_w    = 1'b1;
          id_ex_w    = 1'b1;
          ex_mem_w   = 1'b1;
          if (redirect) begin
            // Decode and fetch both hold wrong-path instructions, so load-use is moot.
            if_id_f   = 1'b1;
            id_ex_f   = 1'b1;
            flush_evt = 1'b1;
          end else if (load_use) begin
            pc_w      = 1'b0;
            if_id_w   = 1'b0;
            id_ex_f   = 1'b1;
            stall_evt = 1'b1;
          end
        end
      end
      ERROR: begin
        state_next = ERROR;
        err_next   = 1'b1;
      end
      default: begin
        state_next = RUN;
        wait_next  = '0;
      end
    endcase

    stall_cnt_next  = sat_inc(stall_cnt_reg, stall_evt);
    flush_cnt_next  = sat_inc(flush_cnt_reg, flush_evt);
    freeze_cnt_next = sat_inc(freeze_cnt_reg, freeze_evt);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg      <= RUN;
      wait_reg       <= '0;
      err_reg        <= 1'b0;
      stall_cnt_reg  <= '0;
      flush_cnt_reg  <= '0;
      freeze_cnt_reg <= '0;
    end else begin
      state_reg      <= state_next;
      wait_reg       <= wait_next;
      err_reg        <= err_next;
      stall_cnt_reg  <= stall_cnt_next;
      flush_cnt_reg  <= flush_cnt_next;
      freeze_cnt_reg <= freeze_cnt_next;
    end
  end

  // Reset holds the pipeline with NOPs loaded into both front registers.
  always_comb begin
    PC_WRITE     = pc_w;
    IF_ID_WRITE  = if_id_w;
    ID_EX_WRITE  = id_ex_w;
    EX_MEM_WRITE = ex_mem_w;
    IF_ID_FLUSH  = if_id_f;
    ID_EX_FLUSH  = id_ex_f;
    FWD_A_SEL    = op_fwd[0];
    FWD_B_SEL    = op_fwd[1];
    if (RST) begin
      PC_WRITE     = 1'b0;
      IF_ID_WRITE  = 1'b0;
      ID_EX_WRITE  = 1'b0;
      EX_MEM_WRITE = 1'b0;
      IF_ID_FLUSH  = 1'b1;
      ID_EX_FLUSH  = 1'b1;
      FWD_A_SEL    = FWD_RF;
      FWD_B_SEL    = FWD_RF;
    end
  end

  assign STALL_CNT  = stall_cnt_reg;
  assign FLUSH_CNT  = flush_cnt_reg;
  assign FREEZE_CNT = freeze_cnt_reg;
  assign ERR        = err_reg;

endmodule

// File: tb/tb_otter_hazard_controller.sv
// Scoreboard bench for otter_hazard_controller: directed scenarios then random
// stimulus, checked against a streak-based behavioural model.
module tb_otter_hazard_controller;

  localparam int CNT_W    = 32;
  localparam int WAIT_MAX = 15;
  localparam longint MAXC = (longint'(1) << CNT_W) - 1;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic RST = 1'b1;
  logic [4:0] DEC_RS1 = '0, DEC_RS2 = '0, EX_RS1 = '0, EX_RS2 = '0, EX_RD = '0;
  logic [4:0] MEM_RD = '0, WB_RD = '0;
  logic DEC_USES_RS1 = 0, DEC_USES_RS2 = 0, EX_REGWRITE = 0, EX_MEMREAD2 = 0;
  logic MEM_REGWRITE = 0, WB_REGWRITE = 0, MEM_BUSY = 0;
  logic [1:0] EX_PCSOURCE = '0;
  logic PC_WRITE, IF_ID_WRITE, ID_EX_WRITE, EX_MEM_WRITE, IF_ID_FLUSH, ID_EX_FLUSH, ERR;
  logic [1:0] FWD_A_SEL, FWD_B_SEL;
  logic [CNT_W-1:0] STALL_CNT, FLUSH_CNT, FREEZE_CNT;

  otter_hazard_controller #(.CNT_W(CNT_W), .WAIT_MAX(WAIT_MAX)) dut (
    .CLK(CLK), .RST(RST),
    .DEC_RS1(DEC_RS1), .DEC_RS2(DEC_RS2), .DEC_USES_RS1(DEC_USES_RS1), .DEC_USES_RS2(DEC_USES_RS2),
    .EX_RS1(EX_RS1), .EX_RS2(EX_RS2), .EX_RD(EX_RD), .EX_REGWRITE(EX_REGWRITE),
    .EX_MEMREAD2(EX_MEMREAD2), .EX_PCSOURCE(EX_PCSOURCE),
    .MEM_RD(MEM_RD), .MEM_REGWRITE(MEM_REGWRITE), .WB_RD(WB_RD), .WB_REGWRITE(WB_REGWRITE),
    .MEM_BUSY(MEM_BUSY),
    .PC_WRITE(PC_WRITE), .IF_ID_WRITE(IF_ID_WRITE), .ID_EX_WRITE(ID_EX_WRITE),
    .EX_MEM_WRITE(EX_MEM_WRITE), .IF_ID_FLUSH(IF_ID_FLUSH), .ID_EX_FLUSH(ID_EX_FLUSH),
    .FWD_A_SEL(FWD_A_SEL), .FWD_B_SEL(FWD_B_SEL),
    .STALL_CNT(STALL_CNT), .FLUSH_CNT(FLUSH_CNT), .FREEZE_CNT(FREEZE_CNT), .ERR(ERR)
  );

  typedef struct {
    bit rst;
    bit [4:0] dec_rs1, dec_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    bit dec_u1, dec_u2, ex_rw, ex_ld, mem_rw, wb_rw, busy;
    bit [1:0] ex_pcs;
  } stim_t;

  typedef struct {
    int tag;
    bit regs_valid;
    bit pc_w, ifid_w, idex_w, exmem_w, ifid_f, idex_f, err;
    bit [1:0] fa, fb;
    longint stall, flush, freeze;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int txn = 0;

  // Behavioural model: counters as plain integers, freeze tracked as a busy streak length.
  longint m_stall, m_flush, m_freeze;
  bit m_err = 0;
  bit m_known = 0;
  int m_streak = 0;

  function automatic longint bump(longint v);
    return (v >= MAXC) ? MAXC : v + 1;
  endfunction

  function automatic bit [1:0] ref_fwd(bit [4:0] rs, bit [4:0] mrd, bit mrw, bit [4:0] wrd, bit wrw);
    if (mrw && mrd != 0 && mrd == rs) return 2'd1;
    if (wrw && wrd != 0 && wrd == rs) return 2'd2;
    return 2'd0;
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s = '{default: '0};
    return s;
  endfunction

  task automatic cycle(input stim_t s);
    exp_t e;
    bit lu;
    @(posedge CLK);
    #1;
    RST = s.rst; DEC_RS1 = s.dec_rs1; DEC_RS2 = s.dec_rs2;
    DEC_USES_RS1 = s.dec_u1; DEC_USES_RS2 = s.dec_u2;
    EX_RS1 = s.ex_rs1; EX_RS2 = s.ex_rs2; EX_RD = s.ex_rd;
    EX_REGWRITE = s.ex_rw; EX_MEMREAD2 = s.ex_ld; EX_PCSOURCE = s.ex_pcs;
    MEM_RD = s.mem_rd; MEM_REGWRITE = s.mem_rw; WB_RD = s.wb_rd; WB_REGWRITE = s.wb_rw;
    MEM_BUSY = s.busy;

    e = '{default: '0};
    e.tag = txn++;
    e.regs_valid = m_known;
    e.stall = m_stall; e.flush = m_flush; e.freeze = m_freeze; e.err = m_err;

    if (s.rst) begin
      e.ifid_f = 1; e.idex_f = 1;
      m_stall = 0; m_flush = 0; m_freeze = 0; m_err = 0; m_streak = 0; m_known = 1;
    end else begin
      e.fa = ref_fwd(s.ex_rs1, s.mem_rd, s.mem_rw, s.wb_rd, s.wb_rw);
      e.fb = ref_fwd(s.ex_rs2, s.mem_rd, s.mem_rw, s.wb_rd, s.wb_rw);
      if (m_err) begin
        // watchdog tripped: frozen until reset
      end else if (s.busy) begin
        m_freeze = bump(m_freeze);
        m_streak++;
        if (m_streak >= WAIT_MAX) m_err = 1;
      end else begin
        m_streak = 0;
        e.pc_w = 1; e.ifid_w = 1; e.idex_w = 1; e.exmem_w = 1;
        lu = s.ex_ld && s.ex_rw && s.ex_rd != 0 &&
             ((s.dec_u1 && s.dec_rs1 == s.ex_rd) || (s.dec_u2 && s.dec_rs2 == s.ex_rd));
        if (s.ex_pcs != 0) begin
          e.ifid_f = 1; e.idex_f = 1;
          m_flush = bump(m_flush);
        end else if (lu) begin
          e.pc_w = 0; e.ifid_w = 0; e.idex_f = 1;
          m_stall = bump(m_stall);
        end
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input int tag, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s txn %0d: got %0d, expected %0d", name, tag, act, req);
    end
  endtask

  // Monitor: the DUT presents a fresh set of outputs every cycle; sample mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        $display("txn %0d rst=%0b busy=%0b pcs=%0d pcw=%0b ifidw=%0b idexw=%0b exmemw=%0b ifidf=%0b idexf=%0b fa=%0d fb=%0d stall=%0d flush=%0d freeze=%0d err=%0b",
                 e.tag, RST, MEM_BUSY, EX_PCSOURCE, PC_WRITE, IF_ID_WRITE, ID_EX_WRITE, EX_MEM_WRITE,
                 IF_ID_FLUSH, ID_EX_FLUSH, FWD_A_SEL, FWD_B_SEL, STALL_CNT, FLUSH_CNT, FREEZE_CNT, ERR);
        chk("pc_write", e.tag, longint'(PC_WRITE), longint'(e.pc_w));
        chk("if_id_write", e.tag, longint'(IF_ID_WRITE), longint'(e.ifid_w));
        chk("id_ex_write", e.tag, longint'(ID_EX_WRITE), longint'(e.idex_w));
        chk("ex_mem_write", e.tag, longint'(EX_MEM_WRITE), longint'(e.exmem_w));
        chk("if_id_flush", e.tag, longint'(IF_ID_FLUSH), longint'(e.ifid_f));
        chk("id_ex_flush", e.tag, longint'(ID_EX_FLUSH), longint'(e.idex_f));
        chk("fwd_a_sel", e.tag, longint'(FWD_A_SEL), longint'(e.fa));
        chk("fwd_b_sel", e.tag, longint'(FWD_B_SEL), longint'(e.fb));
        if (e.regs_valid) begin
          chk("stall_cnt", e.tag, longint'(STALL_CNT), e.stall);
          chk("flush_cnt", e.tag, longint'(FLUSH_CNT), e.flush);
          chk("freeze_cnt", e.tag, longint'(FREEZE_CNT), e.freeze);
          chk("err", e.tag, longint'(ERR), longint'(e.err));
        end
      end
    end
  end

  function automatic stim_t load_use_stim();
    stim_t s;
    s = idle();
    s.ex_ld = 1; s.ex_rw = 1; s.ex_rd = 5;
    s.dec_u1 = 1; s.dec_rs1 = 5; s.dec_u2 = 1; s.dec_rs2 = 1;
    return s;
  endfunction

  initial begin
    stim_t s;
    int busy_left;

    // reset
    s = idle(); s.rst = 1;
    repeat (2) cycle(s);
    cycle(idle());

    // load-use bubble, then WB forwarding of the load result
    cycle(load_use_stim());
    s = idle(); s.ex_rs1 = 5; s.wb_rd = 5; s.wb_rw = 1;
    cycle(s);
    cycle(idle());

    // forwarding priority and x0 suppression on both operands
    s = idle(); s.ex_rs1 = 3; s.ex_rs2 = 3; s.mem_rd = 3; s.mem_rw = 1; s.wb_rd = 3; s.wb_rw = 1;
    cycle(s);
    s.mem_rd = 0;
    cycle(s);
    s.ex_rs1 = 0; s.ex_rs2 = 0; s.wb_rd = 0;
    cycle(s);

    // redirect overrides load-use
    s = load_use_stim(); s.ex_pcs = 2;
    cycle(s);
    cycle(idle());

    // freeze with a pending branch, flush fires as the bus frees
    s = idle(); s.ex_pcs = 1; s.busy = 1;
    repeat (3) cycle(s);
    s.busy = 0;
    cycle(s);
    cycle(idle());

    // one cycle short of the watchdog limit
    s = idle(); s.busy = 1;
    repeat (WAIT_MAX - 1) cycle(s);
    cycle(idle());

    // watchdog trip, stays frozen, cleared by a one-cycle reset
    s = idle(); s.busy = 1;
    repeat (WAIT_MAX) cycle(s);
    repeat (3) cycle(load_use_stim());
    s = idle(); s.rst = 1;
    cycle(s);
    repeat (2) cycle(idle());

    // randomized traffic, busy bursts long enough to sometimes trip the watchdog
    busy_left = 0;
    for (int i = 0; i < 1500; i++) begin
      s.rst = ($urandom_range(0, 99) == 0);
      s.dec_rs1 = 5'($urandom_range(0, 7)); s.dec_rs2 = 5'($urandom_range(0, 7));
      s.ex_rs1 = 5'($urandom_range(0, 7));  s.ex_rs2 = 5'($urandom_range(0, 7));
      s.ex_rd = 5'($urandom_range(0, 7));   s.mem_rd = 5'($urandom_range(0, 7));
      s.wb_rd = 5'($urandom_range(0, 7));
      s.dec_u1 = 1'($urandom_range(0, 1)); s.dec_u2 = 1'($urandom_range(0, 1));
      s.ex_rw = 1'($urandom_range(0, 1));  s.ex_ld = 1'($urandom_range(0, 1));
      s.mem_rw = 1'($urandom_range(0, 1)); s.wb_rw = 1'($urandom_range(0, 1));
      s.ex_pcs = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      if (busy_left == 0 && $urandom_range(0, 9) == 0) busy_left = $urandom_range(1, 18);
      s.busy = (busy_left > 0);
      if (busy_left > 0) busy_left--;
      cycle(s);
    end

    // saturation: preload STALL_CNT to all-ones, then a load-use must not wrap it
    s = idle(); s.rst = 1;
    cycle(s);
    cycle(idle());
    @(negedge CLK);
    #1;
    force dut.stall_cnt_reg = {CNT_W{1'b1}};
    #1;
    release dut.stall_cnt_reg;
    m_stall = MAXC;
    cycle(load_use_stim());
    repeat (2) cycle(idle());

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge CLK);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d transactions left unchecked, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
